// File: rtl/pipeline_debug_unit.sv
// UART-driven debug controller for the five-stage pipeline: steps/runs/resets the PC
// and streams a 6-word snapshot out MSB-first. Optional halt detection: DEBUG_HALT_DETECT_EN.
module pipeline_debug_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  pc_enable,
    output logic                  pc_reset,
    input  logic [DATA_WIDTH-1:0] pc_addr_in,
    input  logic [DATA_WIDTH-1:0] pc_instr_in,
    input  logic [DATA_WIDTH-1:0] reg_w_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rt_data_in,
    input  logic [DATA_WIDTH-1:0] reg_rs_data_in,
    output logic                  busy
);
    localparam int NWORDS = 6;
    localparam int SNAP_W = NWORDS * DATA_WIDTH;
    localparam int NBYTES = SNAP_W / 8;
    localparam int IDX_W  = $clog2(NBYTES);

    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_D = 8'h44;
    localparam logic [7:0] CMD_P = 8'h50;

    typedef enum logic [2:0] {IDLE, PCRST, STEP, RUN, CAPTURE, SEND} state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   cnt_q;
    logic [SNAP_W-1:0]       snap_q;
    logic [IDX_W-1:0]        idx_q;
    logic [7:0]              tx_data_q;
    logic                    tx_valid_q;
    logic                    pc_enable_q;
    logic                    pc_reset_q;
    logic                    stop_run;

    // Snapshot byte i counted from the MSB end (counter word first).
    function automatic logic [7:0] snap_byte(input logic [SNAP_W-1:0] s, input logic [IDX_W-1:0] i);
        logic [SNAP_W-1:0] sh;
        sh = s << (8 * int'(i));
        return sh[SNAP_W-1 -: 8];
    endfunction

`ifdef DEBUG_HALT_DETECT_EN
    assign stop_run = (rx_valid && rx_data == CMD_P) || (pc_instr_in == HALT_WORD);
`else
    logic unused_halt;
    assign unused_halt = ^HALT_WORD;
    assign stop_run    = rx_valid && rx_data == CMD_P;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            snap_q      <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            pc_enable_q <= 1'b0;
            pc_reset_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_q + {{(DATA_WIDTH-1){1'b0}}, pc_enable_q};
            pc_reset_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            CMD_R: begin state_q <= PCRST; pc_reset_q  <= 1'b1; end
                            CMD_S: begin state_q <= STEP;  pc_enable_q <= 1'b1; end
                            CMD_C: begin state_q <= RUN;   pc_enable_q <= 1'b1; end
                            CMD_D: state_q <= CAPTURE;
                            default: ;
                        endcase
                    end
                end
                PCRST: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                STEP: begin
                    pc_enable_q <= 1'b0;
                    state_q     <= CAPTURE;
                end
                RUN: begin
                    if (stop_run) begin
                        pc_enable_q <= 1'b0;
                        state_q     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Counter already includes the final enabled cycle here.
                    snap_q     <= {cnt_q, pc_addr_in, pc_instr_in, reg_w_data_in,
                                   reg_rt_data_in, reg_rs_data_in};
                    idx_q      <= '0;
                    tx_data_q  <= cnt_q[DATA_WIDTH-1 -: 8];
                    tx_valid_q <= 1'b1;
                    state_q    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx_q == IDX_W'(NBYTES - 1)) begin
                            idx_q      <= '0;
                            tx_data_q  <= '0;
                            tx_valid_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            idx_q     <= idx_q + 1'b1;
                            tx_data_q <= snap_byte(snap_q, IDX_W'(idx_q + 1'b1));
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign pc_enable = pc_enable_q;
    assign pc_reset  = pc_reset_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/pipeline_debug_unit.md
# pipeline_debug_unit

Sequential debug controller that sits directly upstream of the five-stage MIPS pipeline top. It drives the pipeline's `pc_enable`/`pc_reset` inputs from single-byte UART commands and consumes the pipeline's debug outputs (PC, instruction, write-back data, rs/rt data). It captures these outputs into a snapshot and streams it out byte-by-byte over a valid/ready TX handshake.

## Interface
- `DATA_WIDTH`, 32: width of every pipeline debug word and the cycle counter.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding treated as halt, used only with `DEBUG_HALT_DETECT_EN`.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `rx_data` in 8: received command byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid this cycle.
- `tx_data` out 8: snapshot byte.
- `tx_valid` out 1: `tx_data` holds a byte for transfer.
- `tx_ready` in 1: the sink accepts the byte.
- `pc_enable` out 1: drives the pipeline's PC enable.
- `pc_reset` out 1: drives the pipeline's PC reset.
- `pc_addr_in`, `pc_instr_in`, `reg_w_data_in`, `reg_rt_data_in`, `reg_rs_data_in` in `DATA_WIDTH`: pipeline debug outputs.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, PCRST, STEP, RUN, CAPTURE, SEND.
- Commands are accepted only in IDLE. In RUN, only `'P'` is accepted. Every other byte is dropped silently.
  - `'R'` (0x52): go to PCRST, then back to IDLE.
  - `'S'` (0x53): STEP, then CAPTURE, then SEND.
  - `'C'` (0x43): go to RUN.
  - `'D'` (0x44): CAPTURE, then SEND, without advancing the pipeline.
  - Any other byte: ignored.
- PCRST: `pc_reset` is high for exactly one cycle and the cycle counter clears to 0.
- STEP: `pc_enable` is high for exactly one cycle.
- RUN: `pc_enable` stays high until `'P'` (0x50) is received, then the block goes to CAPTURE.
- Cycle counter: 32 bits, increments on every cycle in which `pc_enable` is high. It wraps from 0xFFFF_FFFF to 0.
- CAPTURE: one cycle. Latches the cycle counter and the five input words into a 6-word snapshot.
- SEND: emits 24 bytes in this order: cycle counter, pc_addr, pc_instr, reg_w_data, reg_rt_data, reg_rs_data. Each word is sent MSB byte first.
  - The byte index advances only when `tx_valid && tx_ready`.
  - After byte 23 transfers, the next state is IDLE.
- `pc_enable` and `pc_reset` are registered outputs. They are never high at the same time.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `pc_enable`=0, `pc_reset`=0, `busy`=0, counter=0, byte index=0, snapshot=0. State resets to IDLE.
- Reset asserted mid-SEND or mid-RUN: the block aborts immediately and the partial frame is discarded.
- `'S'` strobed at cycle N:
  - `pc_enable`=1 in cycle N+1.
  - CAPTURE in cycle N+2, sampling the post-edge pipeline outputs.
  - `tx_valid`=1 with byte 0 from cycle N+3.
- `'D'` at cycle N: CAPTURE at N+1, first `tx_valid` at N+2.
- `'P'` at cycle N in RUN: `pc_enable`=0 from N+1, CAPTURE at N+1, `tx_valid` from N+2.
- `'R'` at cycle N: `pc_reset`=1 in N+1 only; `busy` falls at N+2.
- TX rules:
  - `tx_data` stays stable while `tx_valid && !tx_ready`.
  - With `tx_ready` tied high, one byte transfers per cycle and a frame takes 24 cycles.
  - `tx_valid` never deasserts mid-frame.
- `busy` is high exactly when state ≠ IDLE.

## Configuration
- `DEBUG_HALT_DETECT_EN` defined: in RUN, if `pc_instr_in == HALT_WORD` is sampled at cycle N, then `pc_enable`=0 from N+1 and CAPTURE occurs at N+1, the same as for `'P'`.
  - If halt detection and `'P'` occur in the same cycle, exactly one frame is sent.
- `DEBUG_HALT_DETECT_EN` undefined: `HALT_WORD` is unused and RUN ends only on `'P'` or `reset`.

## Test plan
- Reset, then `'D'` with inputs pc=0x0000_0004, instr=0x2002_0005, w=0x11, rt=0x22, rs=0x33, and `tx_ready`=1 -> 24 bytes: 00 00 00 00, 00 00 00 04, 20 02 00 05, 00 00 00 11, 00 00 00 22, 00 00 00 33. `pc_enable` never goes high.
- `'S'` three times -> exactly three single-cycle `pc_enable` pulses. The third frame's counter bytes are 00 00 00 03.
- `'C'`, wait 100 cycles, then `'P'` -> counter bytes equal the number of `pc_enable`-high cycles (101 with strobe timing per Timing). Any `'S'` sent during RUN is ignored.
- During SEND, toggle `tx_ready` 1/0 on alternate cycles and inject `'R'` -> `tx_data` stays stable while not ready, all 24 bytes arrive in order, and the `'R'` is dropped (`pc_reset` stays 0).
- `'R'` after a run -> `pc_reset` is a one-cycle pulse. The next `'D'` frame shows counter 0.
- With `DEBUG_HALT_DETECT_EN`: `'C'`, then drive `pc_instr_in`=0xFFFF_FFFF at cycle K -> `pc_enable`=0 at K+1 and the frame starts at K+2. Without the macro, the pipeline keeps running.
- Assert `reset` mid-frame (byte 10) -> all outputs are 0 next cycle, `busy`=0, and the next `'D'` restarts at byte 0.
